// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b, LSB first.
// Ports: clk, rst (async high), start/a/b in; busy/done/diff/borrow out;
// zero/ovf out only when SERIAL_SUB_FLAGS_EN is defined.
module serial_subtractor #(
   parameter int WIDTH = 18
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow
`ifdef SERIAL_SUB_FLAGS_EN
   ,
   output logic             zero,
   output logic             ovf
`endif
);

   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             br_q, br_d;
   logic             borrow_q, borrow_d;

   logic             x, y, d_bit, br_nxt, last;
   logic [WIDTH-1:0] res_nxt;

   always_comb begin
      x       = a_q[0];
      y       = b_q[0];
      d_bit   = x ^ y ^ br_q;
      br_nxt  = (~x & y) | (~(x ^ y) & br_q);
      res_nxt = {d_bit, res_q[WIDTH-1:1]};
      last    = (cnt_q == CW'(WIDTH - 1));
   end

`ifdef SERIAL_SUB_FLAGS_EN
   logic as_q, as_d;
   logic bs_q, bs_d;
   logic zero_q, zero_d;
   logic ovf_q, ovf_d;
`endif

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      res_d    = res_q;
      cnt_d    = cnt_q;
      br_d     = br_q;
      borrow_d = borrow_q;
`ifdef SERIAL_SUB_FLAGS_EN
      as_d     = as_q;
      bs_d     = bs_q;
      zero_d   = zero_q;
      ovf_d    = ovf_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               cnt_d   = '0;
               br_d    = 1'b0;
               state_d = S_SHIFT;
`ifdef SERIAL_SUB_FLAGS_EN
               as_d    = a[WIDTH-1];
               bs_d    = b[WIDTH-1];
`endif
            end
         end
         S_SHIFT: begin
            res_d = res_nxt;
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            br_d  = br_nxt;
            cnt_d = cnt_q + CW'(1);
            if (last) begin
               state_d  = S_DONE;
               borrow_d = br_nxt;
`ifdef SERIAL_SUB_FLAGS_EN
               zero_d   = (res_nxt == '0);
               // Overflow: operand signs differ and result sign left a's sign
               ovf_d    = (as_q != bs_q) && (d_bit != as_q);
`endif
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         res_q    <= '0;
         cnt_q    <= '0;
         br_q     <= 1'b0;
         borrow_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         res_q    <= res_d;
         cnt_q    <= cnt_d;
         br_q     <= br_d;
         borrow_q <= borrow_d;
      end
   end

`ifdef SERIAL_SUB_FLAGS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         as_q   <= 1'b0;
         bs_q   <= 1'b0;
         zero_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         as_q   <= as_d;
         bs_q   <= bs_d;
         zero_q <= zero_d;
         ovf_q  <= ovf_d;
      end
   end

   assign zero = zero_q;
   assign ovf  = ovf_q;
`endif

   assign busy   = (state_q == S_SHIFT);
   assign done   = (state_q == S_DONE);
   assign diff   = res_q;
   assign borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor against an arithmetic model.
// Flags are checked only when SERIAL_SUB_FLAGS_EN is defined.
module tb_serial_subtractor;

   localparam int W = 18;
   localparam longint MASK = (64'd1 << W) - 1;

   logic         clk;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] diff;
   logic         borrow;
`ifdef SERIAL_SUB_FLAGS_EN
   logic         zero;
   logic         ovf;
`endif

   int tests = 0;
   int fails = 0;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .diff  (diff),
      .borrow(borrow)
`ifdef SERIAL_SUB_FLAGS_EN
      ,
      .zero  (zero),
      .ovf   (ovf)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic longint sx(input logic [W-1:0] v);
      return v[W-1] ? longint'(v) - (64'd1 << W) : longint'(v);
   endfunction

   task automatic check_result(input string tag, input logic [W-1:0] av,
                               input logic [W-1:0] bv);
      longint ed;
      longint sr;
      ed = (longint'(av) - longint'(bv)) & MASK;
      sr = sx(av) - sx(bv);
      chk({tag, ".diff"}, 32'(diff), 32'(ed));
      chk({tag, ".borrow"}, 32'(borrow), 32'(av < bv));
`ifdef SERIAL_SUB_FLAGS_EN
      chk({tag, ".zero"}, 32'(zero), 32'(ed == 0));
      chk({tag, ".ovf"}, 32'(ovf),
          32'((sr > (64'sd1 <<< (W-1)) - 1) || (sr < -(64'sd1 <<< (W-1)))));
`else
      if (sr == 64'sd0) tests = tests + 0;
`endif
   endtask

   task automatic do_op(input string tag, input logic [W-1:0] av,
                        input logic [W-1:0] bv, input bit timing);
      @(negedge clk);
      a = av; b = bv; start = 1'b1;
      for (int k = 0; k <= W + 1; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (k == 0) begin
            start = 1'b0;
            a = W'($urandom);
            b = W'($urandom);
         end
         if (k < W) begin
            if (timing || k == 0) begin
               chk({tag, ".busy"}, 32'(busy), 32'd1);
               chk({tag, ".nodone"}, 32'(done), 32'd0);
            end
         end else if (k == W) begin
            chk({tag, ".busy_end"}, 32'(busy), 32'd0);
            chk({tag, ".done"}, 32'(done), 32'd1);
            check_result(tag, av, bv);
         end else begin
            chk({tag, ".done_drop"}, 32'(done), 32'd0);
            check_result({tag, ".hold"}, av, bv);
         end
      end
   endtask

   initial begin
      int nd;
      int e1;
      int e2;
      rst = 1'b1; start = 1'b0; a = '0; b = '0;
      #1;
      chk("rst.busy", 32'(busy), 32'd0);
      chk("rst.done", 32'(done), 32'd0);
      chk("rst.diff", 32'(diff), 32'd0);
      chk("rst.borrow", 32'(borrow), 32'd0);
`ifdef SERIAL_SUB_FLAGS_EN
      chk("rst.zero", 32'(zero), 32'd0);
      chk("rst.ovf", 32'(ovf), 32'd0);
`endif
      repeat (2) @(negedge clk);
      rst = 1'b0;

      do_op("t5m3", W'(5), W'(3), 1'b1);
      do_op("t3m5", W'(3), W'(5), 1'b1);
      do_op("tovf", W'(18'h1FFFF), W'(18'h3FFFF), 1'b1);

      // Back-to-back via held start; operands change after accept
      @(negedge clk);
      a = W'(18'h12345); b = W'(18'h12345); start = 1'b1;
      nd = 0; e1 = -1; e2 = -1;
      for (int e = 0; e < 45; e++) begin
         @(posedge clk);
         @(negedge clk);
         if (e == 0) begin a = W'(7); b = W'(2); end
         if (e == 20) start = 1'b0;
         if (done) begin
            nd++;
            if (nd == 1) begin
               e1 = e;
               check_result("b2b1", W'(18'h12345), W'(18'h12345));
            end else begin
               e2 = e;
               check_result("b2b2", W'(7), W'(2));
            end
         end
      end
      chk("b2b.count", 32'(nd), 32'd2);
      chk("b2b.first", 32'(e1), 32'd18);
      chk("b2b.space", 32'(e2 - e1), 32'd20);

      // start during SHIFT is ignored
      @(negedge clk);
      a = W'(10); b = W'(4); start = 1'b1;
      nd = 0;
      for (int e = 0; e < 40; e++) begin
         @(posedge clk);
         @(negedge clk);
         if (e == 0) start = 1'b0;
         if (e == 5) begin start = 1'b1; a = W'(1); b = W'(1); end
         if (e == 6) start = 1'b0;
         if (done) begin
            nd++;
            chk("ign.edge", 32'(e), 32'd18);
            check_result("ign", W'(10), W'(4));
         end
      end
      chk("ign.count", 32'(nd), 32'd1);

      // Async reset mid-operation
      @(negedge clk);
      a = W'(100); b = W'(3); start = 1'b1;
      for (int e = 0; e < 8; e++) begin
         @(posedge clk);
         @(negedge clk);
         if (e == 0) start = 1'b0;
      end
      chk("arst.busy_pre", 32'(busy), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("arst.busy", 32'(busy), 32'd0);
      chk("arst.done", 32'(done), 32'd0);
      chk("arst.diff", 32'(diff), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      nd = 0;
      for (int e = 0; e < 25; e++) begin
         @(posedge clk);
         @(negedge clk);
         if (done) nd++;
      end
      chk("arst.nodone", 32'(nd), 32'd0);
      do_op("t0m1", W'(0), W'(1), 1'b1);
      do_op("teq", W'(18'h2AAAA), W'(18'h2AAAA), 1'b0);
      do_op("tmin", W'(18'h20000), W'(1), 1'b0);

      for (int i = 0; i < 20; i++) begin
         do_op("rnd", W'($urandom), W'($urandom), 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      fails++;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
